// File: rtl/wb_commit_pkg.sv
// Shared widths, constants and state encoding for the writeback/commit block.
// Optional feature macro: WB_COMMIT_BYPASS_EN (same-cycle write-to-read bypass).
package wb_commit_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 64;

  localparam logic [XLEN-1:0] PC_START  = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    WB_BOOT = 2'd0,
    WB_RUN  = 2'd1,
    WB_HALT = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_regfile.sv
// Integer register file: 1 write port, 2 combinational read ports, x0 hardwired zero.
// With WB_COMMIT_BYPASS_EN defined, a same-cycle write is forwarded to matching read ports.
module wb_regfile
  import wb_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next register state: apply the single write, keep x0 at zero
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we_i) begin
      regs_d[waddr_i] = wdata_i;
    end
    regs_d[0] = ZERO_WORD;
  end

  // Register array storage; reset clears every entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= ZERO_WORD;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read ports; address 0 always reads zero
  always_comb begin
    rdata1_o = (raddr1_i == '0) ? ZERO_WORD : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == '0) ? ZERO_WORD : regs_q[raddr2_i];
`ifdef WB_COMMIT_BYPASS_EN
    if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
    if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
`endif
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: owns architectural PC, register file and retired count.
// Optional feature macro: WB_COMMIT_BYPASS_EN (forwarded to wb_regfile).
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              wb_ready_o,
  input  logic [XLEN-1:0]   result_i,
  input  logic              wena_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   dnpc_i,
  input  logic              halt_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [CNT_W-1:0]  instret_o,
  output logic              halted_o
);

  wb_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             ready_q, ready_d;
  logic             halted_q, halted_d;
  logic             commit_c;
  logic             reg_we_c;

  // A commit is a handshake while ready (ready is only high in RUN)
  assign commit_c = ex_valid_i & ready_q;
  assign reg_we_c = commit_c & wena_i;

  // Next-state, PC, counter and registered-output computation
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    case (state_q)
      WB_BOOT: state_d = WB_RUN;
      WB_RUN: begin
        if (commit_c) begin
          pc_d      = dnpc_i;
          instret_d = instret_q + CNT_W'(1);
          if (halt_i) begin
            state_d = WB_HALT;
          end
        end
      end
      WB_HALT: state_d = WB_HALT;
      default: state_d = WB_BOOT;
    endcase
    ready_d  = (state_d == WB_RUN);
    halted_d = (state_d == WB_HALT);
  end

  // State and architectural registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WB_BOOT;
      pc_q      <= PC_START;
      instret_q <= '0;
      ready_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      ready_q   <= ready_d;
      halted_q  <= halted_d;
    end
  end

  assign wb_ready_o = ready_q;
  assign pc_o       = pc_q;
  assign instret_o  = instret_q;
  assign halted_o   = halted_q;

  wb_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (reg_we_c),
    .waddr_i  (waddr_i),
    .wdata_i  (result_i),
    .raddr1_i (raddr1_i),
    .raddr2_i (raddr2_i),
    .rdata1_o (rdata1_o),
    .rdata2_o (rdata2_o)
  );

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit.
module tb_wb_commit;

  logic        clk;
  logic        rst;
  logic        ex_valid_i;
  logic        wb_ready_o;
  logic [63:0] result_i;
  logic        wena_i;
  logic [4:0]  waddr_i;
  logic [63:0] dnpc_i;
  logic        halt_i;
  logic [4:0]  raddr1_i;
  logic [4:0]  raddr2_i;
  logic [63:0] rdata1_o;
  logic [63:0] rdata2_o;
  logic [63:0] pc_o;
  logic [63:0] instret_o;
  logic        halted_o;

  int tests_run;
  int tests_failed;

  localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;

  wb_commit dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid_i (ex_valid_i),
    .wb_ready_o (wb_ready_o),
    .result_i   (result_i),
    .wena_i     (wena_i),
    .waddr_i    (waddr_i),
    .dnpc_i     (dnpc_i),
    .halt_i     (halt_i),
    .raddr1_i   (raddr1_i),
    .raddr2_i   (raddr2_i),
    .rdata1_o   (rdata1_o),
    .rdata2_o   (rdata2_o),
    .pc_o       (pc_o),
    .instret_o  (instret_o),
    .halted_o   (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [4:0] wa, input logic [63:0] res, input logic [63:0] npc,
                        input logic we, input logic hlt);
    ex_valid_i = 1'b1;
    wena_i     = we;
    waddr_i    = wa;
    result_i   = res;
    dnpc_i     = npc;
    halt_i     = hlt;
    step();
    ex_valid_i = 1'b0;
    halt_i     = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b0;
    ex_valid_i = 1'b0;
    result_i   = '0;
    wena_i     = 1'b0;
    waddr_i    = '0;
    dnpc_i     = '0;
    halt_i     = 1'b0;
    raddr1_i   = '0;
    raddr2_i   = '0;

    // Reset held for 3 cycles
    repeat (3) step();
    check("rst_pc", pc_o, PC0);
    check("rst_ready", 64'(wb_ready_o), 64'd0);
    check("rst_instret", instret_o, 64'd0);
    check("rst_halted", 64'(halted_o), 64'd0);

    // Release: one bubble cycle in BOOT, then ready
    rst = 1'b1;
    #1;
    check("boot_ready", 64'(wb_ready_o), 64'd0);
    step();
    check("run_ready", 64'(wb_ready_o), 64'd1);
    check("run_instret", instret_o, 64'd0);
    check("run_pc", pc_o, PC0);

    // Basic commit
    raddr1_i = 5'd5;
    commit(5'd5, 64'hDEAD_BEEF, 64'h8000_0004, 1'b1, 1'b0);
    check("basic_rdata1", rdata1_o, 64'hDEAD_BEEF);
    check("basic_pc", pc_o, 64'h8000_0004);
    check("basic_instret", instret_o, 64'd1);

    // x0 protection
    commit(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0008, 1'b1, 1'b0);
    raddr1_i = 5'd0;
    raddr2_i = 5'd0;
    #1;
    check("x0_rdata1", rdata1_o, 64'd0);
    check("x0_rdata2", rdata2_o, 64'd0);
    check("x0_pc", pc_o, 64'h8000_0008);
    check("x0_instret", instret_o, 64'd2);

    // Stall with toggling data inputs
    raddr2_i = 5'd5;
    for (int i = 0; i < 4; i++) begin
      result_i = {$urandom, $urandom};
      dnpc_i   = {$urandom, $urandom};
      wena_i   = 1'b1;
      waddr_i  = 5'($urandom_range(1, 31));
      halt_i   = 1'($urandom);
      step();
    end
    halt_i = 1'b0;
    check("stall_pc", pc_o, 64'h8000_0008);
    check("stall_instret", instret_o, 64'd2);
    check("stall_x5", rdata2_o, 64'hDEAD_BEEF);
    check("stall_halted", 64'(halted_o), 64'd0);

    // Same-cycle read/write on x7
    commit(5'd7, 64'h55, 64'h8000_000C, 1'b1, 1'b0);
    raddr1_i   = 5'd7;
    raddr2_i   = 5'd7;
    ex_valid_i = 1'b1;
    wena_i     = 1'b1;
    waddr_i    = 5'd7;
    result_i   = 64'h1234;
    dnpc_i     = 64'h8000_0010;
    #1;
`ifdef WB_COMMIT_BYPASS_EN
    check("rw_same_rdata1", rdata1_o, 64'h1234);
    check("rw_same_rdata2", rdata2_o, 64'h1234);
`else
    check("rw_same_rdata1", rdata1_o, 64'h55);
    check("rw_same_rdata2", rdata2_o, 64'h55);
`endif
    step();
    ex_valid_i = 1'b0;
    check("rw_next_rdata1", rdata1_o, 64'h1234);
    check("rw_next_rdata2", rdata2_o, 64'h1234);
    check("rw_instret", instret_o, 64'd4);
    check("rw_pc", pc_o, 64'h8000_0010);

    // Halt: preload x10 so the halting write of zero is observable
    raddr1_i = 5'd10;
    commit(5'd10, 64'hABCD, 64'h8000_0014, 1'b1, 1'b0);
    check("pre_halt_x10", rdata1_o, 64'hABCD);
    commit(5'd10, 64'd0, 64'h8000_0100, 1'b1, 1'b1);
    check("halt_x10", rdata1_o, 64'd0);
    check("halt_pc", pc_o, 64'h8000_0100);
    check("halt_halted", 64'(halted_o), 64'd1);
    check("halt_ready", 64'(wb_ready_o), 64'd0);
    check("halt_instret", instret_o, 64'd6);

    // Commit attempt after halt is ignored
    commit(5'd10, 64'h77, 64'h8000_0200, 1'b1, 1'b0);
    step();
    check("post_halt_x10", rdata1_o, 64'd0);
    check("post_halt_pc", pc_o, 64'h8000_0100);
    check("post_halt_instret", instret_o, 64'd6);
    check("post_halt_halted", 64'(halted_o), 64'd1);

    // Asynchronous reset away from a clock edge
    raddr2_i = 5'd5;
    rst = 1'b0;
    #1;
    check("rerst_pc", pc_o, PC0);
    check("rerst_halted", 64'(halted_o), 64'd0);
    check("rerst_ready", 64'(wb_ready_o), 64'd0);
    check("rerst_instret", instret_o, 64'd0);
    check("rerst_x5", rdata2_o, 64'd0);
    step();
    rst = 1'b1;
    #1;
    check("reboot_ready", 64'(wb_ready_o), 64'd0);
    step();
    check("rerun_ready", 64'(wb_ready_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
